// File: rtl/tree_mac_result_collector.sv
// Result sink for the tree-MAC multiply core: scatters (sum, i, k) results into a
// ROWS x COLS buffer and drains the complete matrix row-major over valid/ready.
module tree_mac_result_collector #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int ROWS            = 4,
  parameter int COLS            = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      sum_in,
  input  logic [ADDRESS_WIDTH_I-1:0] addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0] addr_k_in,
  input  logic                       val_in,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [ADDRESS_WIDTH_I-1:0] out_i,
  output logic [ADDRESS_WIDTH_K-1:0] out_k,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic                       out_last,
  output logic                       busy_drain,
  output logic                       err_range,
  output logic                       err_overrun,
  input  logic                       err_clr
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;

  logic [0:0]                 state;
  logic [DATA_WIDTH-1:0]      buf_mem [N];
  logic [N-1:0]               filled;
  logic [CNT_W-1:0]           fill_cnt;
  logic [IDX_W-1:0]           drain_idx;
  logic [ADDRESS_WIDTH_I-1:0] drain_i;
  logic [ADDRESS_WIDTH_K-1:0] drain_k;

  logic             collecting;
  logic             in_range;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic             wr_new;
  logic             fill_done;
  logic             drain_fire;
  logic             drain_end;

  assign collecting = (state == ST_COLLECT);

  // Widen by one bit so ROWS/COLS equal to 2^width still compare correctly.
  assign in_range = ({1'b0, addr_i_in} < (ADDRESS_WIDTH_I + 1)'(ROWS)) &&
                    ({1'b0, addr_k_in} < (ADDRESS_WIDTH_K + 1)'(COLS));

  // Only meaningful when in_range, where the product always fits IDX_W bits.
  assign wr_idx = IDX_W'(addr_i_in) * IDX_W'(COLS) + IDX_W'(addr_k_in);

  assign wr_en      = collecting && val_in && in_range;
  assign wr_new     = wr_en && !filled[wr_idx];
  assign fill_done  = wr_new && (fill_cnt == CNT_W'(N - 1));
  assign drain_fire = !collecting && out_rdy;
  assign drain_end  = drain_fire && out_last;

  assign out_val    = !collecting;
  assign busy_drain = !collecting;
  assign out_last   = !collecting && (drain_idx == IDX_W'(N - 1));
  assign out_data   = collecting ? '0 : buf_mem[drain_idx];
  assign out_i      = drain_i;
  assign out_k      = drain_k;

  // Data storage carries no reset; only the fill bitmap qualifies its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[wr_idx] <= sum_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_COLLECT;
      filled      <= '0;
      fill_cnt    <= '0;
      drain_idx   <= '0;
      drain_i     <= '0;
      drain_k     <= '0;
      err_range   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (wr_new) begin
            filled[wr_idx] <= 1'b1;
            fill_cnt       <= fill_cnt + CNT_W'(1);
          end
          if (fill_done) begin
            state     <= ST_DRAIN;
            drain_idx <= '0;
            drain_i   <= '0;
            drain_k   <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_end) begin
            state     <= ST_COLLECT;
            filled    <= '0;
            fill_cnt  <= '0;
            drain_idx <= '0;
            drain_i   <= '0;
            drain_k   <= '0;
          end else if (drain_fire) begin
            drain_idx <= drain_idx + IDX_W'(1);
            if (drain_k == ADDRESS_WIDTH_K'(COLS - 1)) begin
              drain_k <= '0;
              drain_i <= drain_i + ADDRESS_WIDTH_I'(1);
            end else begin
              drain_k <= drain_k + ADDRESS_WIDTH_K'(1);
            end
          end
        end
        default: state <= ST_COLLECT;
      endcase

      // A new error event in the same cycle as err_clr keeps the flag set.
      err_range   <= (val_in && !in_range) || (err_range && !err_clr);
      err_overrun <= (val_in && !collecting) || (err_overrun && !err_clr);
    end
  end

endmodule

// File: doc/tree_mac_result_collector.md
Name: tree_mac_result_collector

Overview:
- Sink for the tree-MAC multiply core's result stream (sum, addr_i, addr_k, valid).
- Scatters each dot-product result into a ROWS x COLS result buffer, tracks which entries are filled, then drains the full matrix row-major over a valid/ready stream.
- Sits between the multiply core pipeline output and the writeback/DMA path. The core cannot stall, so this block never applies backpressure on its input side.

Parameters:
- DATA_WIDTH, 8, width of one result element.
- ADDRESS_WIDTH_I, 8, width of row index.
- ADDRESS_WIDTH_K, 8, width of column index.
- ROWS, 4, result matrix rows (1..2^ADDRESS_WIDTH_I).
- COLS, 4, result matrix columns (1..2^ADDRESS_WIDTH_K).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sum_in  input  DATA_WIDTH  result element from the multiply core.
- addr_i_in  input  ADDRESS_WIDTH_I  row index of sum_in.
- addr_k_in  input  ADDRESS_WIDTH_K  column index of sum_in.
- val_in  input  1  sum_in/addr_*_in valid this cycle.
- out_data  output  DATA_WIDTH  drained element.
- out_i  output  ADDRESS_WIDTH_I  row index of out_data.
- out_k  output  ADDRESS_WIDTH_K  column index of out_data.
- out_val  output  1  drain stream valid.
- out_rdy  input  1  downstream ready.
- out_last  output  1  marks element (ROWS-1, COLS-1).
- busy_drain  output  1  high while in DRAIN.
- err_range  output  1  sticky: out-of-range address received.
- err_overrun  output  1  sticky: val_in received during DRAIN.
- err_clr  input  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (reset=0, async): state=COLLECT; fill bitmap cleared; fill count=0; drain index=0. All outputs 0. Buffer contents are not reset.
- Buffer: ROWS*COLS entries, index = i*COLS+k. Fill count width is clog2(ROWS*COLS+1).
- COLLECT state:
  - val_in=1 with addr_i_in<ROWS and addr_k_in<COLS: write sum_in at the clock edge and set the bitmap bit.
  - Fill count increments only if the bit was previously clear.
  - A duplicate address overwrites data without changing the count. Last write wins.
- Out-of-range address with val_in=1: write dropped, err_range set.
- On the edge where the fill count reaches ROWS*COLS: state becomes DRAIN, drain index=0. out_val=1 and busy_drain=1 from the next cycle.
- DRAIN state:
  - out_data/out_i/out_k show the entry at the drain index, row-major (k fastest).
  - out_val stays high for the whole drain. Outputs hold stable while out_rdy=0.
  - On out_val&&out_rdy: index advances and the next element is presented the following cycle. No bubbles; 1 element/cycle at full ready.
  - out_last=1 exactly when the index is at ROWS*COLS-1.
  - Handshake on out_last: next cycle state=COLLECT, out_val=0, busy_drain=0, bitmap and count cleared.
- val_in=1 during DRAIN, including the final handshake cycle: data dropped, err_overrun set. No effect on the drain.
- Simultaneous events:
  - err_clr and an error event in the same cycle: the set wins.
  - Final-fill write and out_rdy in the same cycle: out_rdy is ignored (out_val is still 0).
- ROWS*COLS=1: DRAIN lasts one element, with out_last asserted on it.
- Reset asserted mid-drain: immediate return to COLLECT, out_val=0, all pending data discarded.
- No arithmetic is performed on data; widths pass through unchanged.

Test Plan:
- ROWS=COLS=2. Write (0,0)=3, (0,1)=5, (1,0)=7, (1,1)=9 in consecutive cycles with out_rdy=1 → out_val rises the cycle after the 4th write. Stream is 3,5,7,9 with (i,k)=(0,0),(0,1),(1,0),(1,1). out_last only on 9. Then back to COLLECT.
- Same writes in order (1,1),(0,0),(1,0),(0,1), with (0,0) rewritten as 8 before (1,0) → drain order still row-major, element (0,0)=8, count unaffected by the duplicate.
- During drain, hold out_rdy=0 for 3 cycles on element 2 → out_data=5, out_i=0, out_k=1 stable for those cycles. Total drain takes 7 cycles.
- val_in with addr_i_in=2 (ROWS=2) → err_range=1, no buffer change. Pulse err_clr → err_range=0 the next cycle.
- val_in=1 while busy_drain=1 → err_overrun=1, drained values unchanged.
- Assert reset after the 2nd drained element → out_val=0 immediately. After release, 4 new writes re-drain correctly from index 0.
